// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch with one outstanding memory request, an output
//            slot and a 1-entry skid buffer. Optional macro
//            FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_d,
  input  logic [31:0] branch_next_addr_d,
  input  logic        stall_f,
  input  logic        flush_f,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_f,
  output logic [31:0] pc_f,
  output logic        mem_valid_f,
  output logic        misalign_f
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_slot_valid, r_skid_valid;
  logic [31:0] r_slot_instr, r_slot_pc;
  logic [31:0] r_skid_instr, r_skid_pc;
  logic        w_ack, w_outstanding, w_rsp_keep, w_slot_free;
  logic [31:0] w_target;
  logic        w_misalign_br, w_misalign_q, w_misalign_nxt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_target       = branch_next_addr_d;
  assign w_misalign_br  = branch_d && (branch_next_addr_d[1:0] != 2'b00);
  assign w_misalign_q   = r_misalign;
  assign w_misalign_nxt = r_misalign | w_misalign_br;

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign_nxt;
  end
`else
  logic w_unused_low;

  assign w_target       = {branch_next_addr_d[31:2], 2'b00};
  assign w_misalign_br  = 1'b0;
  assign w_misalign_q   = 1'b0;
  assign w_misalign_nxt = 1'b0;
  assign w_unused_low   = ^branch_next_addr_d[1:0];
`endif

  assign imem_req      = (r_state == S_REQ) && !r_skid_valid;
  assign imem_addr     = r_fetch_pc;
  assign w_ack         = imem_req && imem_ack;
  assign w_outstanding = w_ack || ((r_state == S_WAIT) && !imem_rvalid);
  // A response landing on the same edge as a redirect belongs to the old path
  assign w_rsp_keep    = (r_state == S_WAIT) && imem_rvalid && !r_kill && !branch_d;
  // Flush frees the slot exactly like a consume, but the old contents are lost
  assign w_slot_free   = !r_slot_valid || !stall_f || flush_f;

  assign instruction_f = r_slot_valid ? r_slot_instr : 32'd0;
  assign pc_f          = r_slot_valid ? r_slot_pc : 32'd0;
  assign mem_valid_f   = r_slot_valid;
  assign misalign_f    = w_misalign_q;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_kill_nxt     = r_kill;
    case (r_state)
      S_REQ: begin
        if (w_ack) begin
          w_state_nxt    = S_WAIT;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_req_pc_nxt   = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = (r_kill && w_misalign_q) ? S_HALT : S_REQ;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (branch_d && (r_state != S_HALT)) begin
      w_fetch_pc_nxt = w_target;
      if (w_outstanding) begin
        w_kill_nxt  = 1'b1;
        w_state_nxt = S_WAIT;
      end else begin
        w_kill_nxt  = 1'b0;
        w_state_nxt = w_misalign_nxt ? S_HALT : S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_kill       <= 1'b0;
      r_slot_valid <= 1'b0;
      r_slot_instr <= 32'd0;
      r_slot_pc    <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_kill     <= w_kill_nxt;
      if (branch_d) begin
        r_slot_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_slot_free) begin
        if (r_skid_valid) begin
          r_slot_valid <= 1'b1;
          r_slot_instr <= r_skid_instr;
          r_slot_pc    <= r_skid_pc;
          r_skid_valid <= w_rsp_keep;
          r_skid_instr <= imem_rdata;
          r_skid_pc    <= r_req_pc;
        end else begin
          r_slot_valid <= w_rsp_keep;
          r_slot_instr <= imem_rdata;
          r_slot_pc    <= r_req_pc;
        end
      end else if (w_rsp_keep) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_req_pc;
      end
    end
  end

endmodule
`default_nettype wire
